// File: rtl/parking_entry_gate.sv
// parking_entry_gate: entry-lane controller with synchronized, debounced loop sensors, ID check and barrier FSM.
// Define GATE_REJECT_STATS_EN to add the saturating reject_count / timeout_count outputs.
module parking_entry_gate #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int ID_TIMEOUT      = 1000,
    parameter int OPEN_TIMEOUT    = 2000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        arrive_raw,
    input  logic        pass_raw,
    input  logic        uni_card,
    input  logic        guest_btn,
    input  logic        uni_is_vacated_space,
    input  logic        is_vacated_space,
    output logic        barrier_open,
    output logic        car_entered,
    output logic        is_uni_car_entered,
    output logic        reject,
    output logic [2:0]  gate_state
`ifdef GATE_REJECT_STATS_EN
    ,
    output logic [15:0] reject_count,
    output logic [15:0] timeout_count
`endif
);
    localparam int TMAX = (ID_TIMEOUT > OPEN_TIMEOUT) ? ID_TIMEOUT : OPEN_TIMEOUT;
    localparam int TW   = $clog2(TMAX) + 1;
    localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_ID    = 3'd1,
        OPEN       = 3'd2,
        PASSING    = 3'd3,
        WAIT_CLEAR = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         sync1_q, sync2_q, filt_q, filt_d;
    logic [1:0][DW-1:0] deb_cnt_q, deb_cnt_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic               reject_q, reject_d, uni_q, uni_d, car_q, car_d, tmo;
    logic               arrive_f, pass_f;

    assign arrive_f = filt_q[0];
    assign pass_f   = filt_q[1];

    // A filtered bit flips only after DEBOUNCE_CYCLES consecutive disagreeing cycles.
    always_comb begin
        filt_d    = filt_q;
        deb_cnt_d = '0;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] != filt_q[i]) begin
                deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
                if (deb_cnt_q[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
                    filt_d[i]    = sync2_q[i];
                    deb_cnt_d[i] = '0;
                end
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        reject_d = reject_q;
        uni_d    = uni_q;
        car_d    = 1'b0;
        tmo      = 1'b0;
        case (state_q)
            IDLE: if (arrive_f) state_d = WAIT_ID;
            WAIT_ID: begin
                if (uni_card || guest_btn) begin
                    if (uni_card ? uni_is_vacated_space : is_vacated_space) begin
                        state_d = OPEN;
                        uni_d   = uni_card;
                    end else begin
                        state_d  = WAIT_CLEAR;
                        reject_d = 1'b1;
                    end
                end else if (!arrive_f) begin
                    state_d = IDLE;
                end else if (timer_q >= TW'(ID_TIMEOUT - 1)) begin
                    state_d = WAIT_CLEAR;
                    tmo     = 1'b1;
                end
            end
            OPEN: begin
                if (pass_f) begin
                    state_d = PASSING;
                end else if (timer_q >= TW'(OPEN_TIMEOUT - 1)) begin
                    state_d = WAIT_CLEAR;
                    tmo     = 1'b1;
                end
            end
            PASSING: begin
                if (!pass_f) begin
                    state_d = IDLE;
                    car_d   = 1'b1;
                end
            end
            WAIT_CLEAR: begin
                if (!arrive_f) begin
                    state_d  = IDLE;
                    reject_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        timer_d = (state_d != state_q) ? '0 : (&timer_q ? timer_q : timer_q + 1'b1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            filt_q    <= '0;
            deb_cnt_q <= '0;
            state_q   <= IDLE;
            timer_q   <= '0;
            reject_q  <= 1'b0;
            uni_q     <= 1'b0;
            car_q     <= 1'b0;
        end else begin
            sync1_q   <= {pass_raw, arrive_raw};
            sync2_q   <= sync1_q;
            filt_q    <= filt_d;
            deb_cnt_q <= deb_cnt_d;
            state_q   <= state_d;
            timer_q   <= timer_d;
            reject_q  <= reject_d;
            uni_q     <= uni_d;
            car_q     <= car_d;
        end
    end

    assign barrier_open       = (state_q == OPEN) || (state_q == PASSING);
    assign car_entered        = car_q;
    assign is_uni_car_entered = uni_q;
    assign reject             = reject_q;
    assign gate_state         = state_q;

`ifdef GATE_REJECT_STATS_EN
    logic [15:0] rej_cnt_q, rej_cnt_d, tmo_cnt_q, tmo_cnt_d;
    always_comb begin
        rej_cnt_d = (reject_d && !reject_q && rej_cnt_q != 16'hFFFF) ? rej_cnt_q + 16'd1 : rej_cnt_q;
        tmo_cnt_d = (tmo && tmo_cnt_q != 16'hFFFF) ? tmo_cnt_q + 16'd1 : tmo_cnt_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            rej_cnt_q <= '0;
            tmo_cnt_q <= '0;
        end else begin
            rej_cnt_q <= rej_cnt_d;
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
    assign reject_count  = rej_cnt_q;
    assign timeout_count = tmo_cnt_q;
`endif
endmodule

// File: tb/tb_parking_entry_gate.sv
// tb_parking_entry_gate: table-driven vectors plus hand sequences for bounce, reset-in-PASSING and open timeout.
module tb_parking_entry_gate;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic arrive_raw = 1'b0, pass_raw = 1'b0, uni_card = 1'b0, guest_btn = 1'b0;
    logic uni_is_vacated_space = 1'b0, is_vacated_space = 1'b0;
    logic barrier_open, car_entered, is_uni_car_entered, reject;
    logic [2:0] gate_state;
`ifdef GATE_REJECT_STATS_EN
    logic [15:0] reject_count, timeout_count;
`endif
    int n_cmp = 0, n_bad = 0, pulses = 0;

    always #5 clk = ~clk;

    parking_entry_gate #(.DEBOUNCE_CYCLES(4), .ID_TIMEOUT(30), .OPEN_TIMEOUT(20)) dut (
        .clk(clk), .rst(rst),
        .arrive_raw(arrive_raw), .pass_raw(pass_raw),
        .uni_card(uni_card), .guest_btn(guest_btn),
        .uni_is_vacated_space(uni_is_vacated_space), .is_vacated_space(is_vacated_space),
        .barrier_open(barrier_open), .car_entered(car_entered),
        .is_uni_car_entered(is_uni_car_entered), .reject(reject), .gate_state(gate_state)
`ifdef GATE_REJECT_STATS_EN
        , .reject_count(reject_count), .timeout_count(timeout_count)
`endif
    );

    always @(negedge clk) if (car_entered) pulses++;

    typedef struct {
        int arrive, pass, uni, guest, uvac, vac, hold;
        int st, bar, rej, uo, pulses;
    } vec_t;
    vec_t vecs[21];

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic guest_accept();
        arrive_raw = 1'b1;
        step(8);
        guest_btn = 1'b1;
        is_vacated_space = 1'b1;
        step(1);
        guest_btn = 1'b0;
    endtask

    initial begin
        int p0, bad;
        //         arr pas uni gst uvac vac hold  st bar rej uo pulses
        vecs = '{
            '{0, 0, 0, 0, 0, 0, 3,   0, 0, 0, 0, 0},
            '{1, 0, 0, 0, 0, 0, 8,   1, 0, 0, 0, 0},
            '{1, 0, 0, 1, 0, 1, 1,   2, 1, 0, 0, 0},
            '{1, 1, 0, 0, 0, 1, 8,   3, 1, 0, 0, 0},
            '{0, 0, 0, 0, 0, 1, 8,   0, 0, 0, 0, 1},
            '{1, 0, 0, 0, 0, 1, 8,   1, 0, 0, 0, 1},
            '{1, 0, 1, 0, 0, 1, 1,   4, 0, 1, 0, 1},
            '{1, 0, 0, 0, 0, 1, 10,  4, 0, 1, 0, 1},
            '{0, 0, 0, 0, 0, 1, 8,   0, 0, 0, 0, 1},
            '{1, 0, 0, 0, 1, 1, 8,   1, 0, 0, 0, 1},
            '{1, 0, 1, 1, 1, 1, 1,   2, 1, 0, 1, 1},
            '{1, 1, 0, 0, 0, 0, 8,   3, 1, 0, 1, 1},
            '{0, 0, 0, 0, 0, 0, 8,   0, 0, 0, 1, 2},
            '{1, 0, 0, 0, 1, 0, 8,   1, 0, 0, 1, 2},
            '{1, 0, 0, 1, 1, 0, 1,   4, 0, 1, 1, 2},
            '{0, 0, 0, 0, 1, 0, 8,   0, 0, 0, 1, 2},
            '{0, 0, 1, 0, 1, 1, 3,   0, 0, 0, 1, 2},
            '{1, 0, 0, 0, 1, 1, 8,   1, 0, 0, 1, 2},
            '{1, 0, 0, 0, 1, 1, 28,  1, 0, 0, 1, 2},
            '{1, 0, 0, 0, 1, 1, 1,   4, 0, 0, 1, 2},
            '{0, 0, 0, 0, 1, 1, 8,   0, 0, 0, 1, 2}
        };
        step(3);
        chk("rst_state", int'(gate_state), 0);
        chk("rst_barrier", int'(barrier_open), 0);
        chk("rst_car", int'(car_entered), 0);
        chk("rst_reject", int'(reject), 0);
        chk("rst_uni", int'(is_uni_car_entered), 0);
        rst = 1'b0;

        for (int i = 0; i < 21; i++) begin
            arrive_raw = vecs[i].arrive[0];
            pass_raw = vecs[i].pass[0];
            uni_is_vacated_space = vecs[i].uvac[0];
            is_vacated_space = vecs[i].vac[0];
            uni_card = vecs[i].uni[0];
            guest_btn = vecs[i].guest[0];
            if (vecs[i].uni != 0 || vecs[i].guest != 0) begin
                step(1);
                uni_card = 1'b0;
                guest_btn = 1'b0;
                step(vecs[i].hold - 1);
            end else begin
                step(vecs[i].hold);
            end
            chk($sformatf("v%0d_state", i), int'(gate_state), vecs[i].st);
            chk($sformatf("v%0d_barrier", i), int'(barrier_open), vecs[i].bar);
            chk($sformatf("v%0d_reject", i), int'(reject), vecs[i].rej);
            chk($sformatf("v%0d_uni", i), int'(is_uni_car_entered), vecs[i].uo);
            chk($sformatf("v%0d_pulses", i), pulses, vecs[i].pulses);
        end
`ifdef GATE_REJECT_STATS_EN
        chk("table_reject_count", int'(reject_count), 2);
        chk("table_timeout_count", int'(timeout_count), 1);
`endif

        // Sensor chatter shorter than the debounce window must never wake the lane.
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            arrive_raw = ~arrive_raw;
            step(2);
            if (gate_state != 3'd0) bad++;
        end
        chk("bounce_idle_cycles", bad, 0);
        step(8);
        chk("bounce_final_state", int'(gate_state), 0);

        guest_accept();
        pass_raw = 1'b1;
        step(8);
        chk("pre_rst_state", int'(gate_state), 3);
        p0 = pulses;
        rst = 1'b1;
        arrive_raw = 1'b0;
        pass_raw = 1'b0;
        step(1);
        chk("rst_pass_state", int'(gate_state), 0);
        chk("rst_pass_barrier", int'(barrier_open), 0);
        rst = 1'b0;
        step(10);
        chk("rst_pass_no_pulse", pulses, p0);
        chk("rst_pass_idle", int'(gate_state), 0);

        guest_accept();
        pass_raw = 1'b1;
        step(8);
        arrive_raw = 1'b0;
        pass_raw = 1'b0;
        step(8);
        chk("post_rst_pulse", pulses, p0 + 1);
        chk("post_rst_uni", int'(is_uni_car_entered), 0);

        rst = 1'b1;
        step(1);
        rst = 1'b0;
        p0 = pulses;
        guest_accept();
        chk("otmo_open_state", int'(gate_state), 2);
        step(19);
        chk("otmo_last_open_state", int'(gate_state), 2);
        chk("otmo_last_open_barrier", int'(barrier_open), 1);
        step(1);
        chk("otmo_state", int'(gate_state), 4);
        chk("otmo_barrier", int'(barrier_open), 0);
        chk("otmo_reject", int'(reject), 0);
        chk("otmo_no_pulse", pulses, p0);
`ifdef GATE_REJECT_STATS_EN
        chk("otmo_reject_count", int'(reject_count), 0);
        chk("otmo_timeout_count", int'(timeout_count), 1);
`endif
        arrive_raw = 1'b0;
        step(8);
        chk("otmo_clear_state", int'(gate_state), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
